ia_uart_frame_loader: RTL and testbench
=======================================

Name: ia_uart_frame_loader

Overview:
Input-assembly front end of the GPU. It receives 8N1 UART bytes from the host PC on one pin and frames them into a fixed-length scene packet: vertices, normal, light, view-projection rows, v3 and render mode. For each payload byte it emits a byte/index/strobe triple for the top-level register file. After the last byte it issues a single packet-complete pulse that starts the vertex stage.

Parameters:
CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200).
SYNC_BYTE, 8'hA5, header byte that opens a packet.
NUM_BYTES, 61, payload bytes per packet; indices run 0..NUM_BYTES-1.
TIMEOUT_CLKS, 65535, idle clocks allowed between payload bytes before the packet is aborted.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx  in  1  asynchronous UART line; idles high
read_data  out  8  last received payload byte; held until the next payload byte
idx  out  6  payload index of read_data, 0..60
update_reg  out  1  one-cycle strobe: read_data/idx valid, write the register
pc_ready  out  1  one-cycle strobe: full packet received
frame_err  out  1  one-cycle strobe: packet aborted (bad stop bit or timeout)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: read_data=0, idx=6'h3F (out of range, so no register matches), update_reg=0, pc_ready=0, frame_err=0. Synchronizer flops reset to 1. Both FSMs go to their first state. Reset mid-byte or mid-packet discards everything in progress.
- rx passes through a 2-flop synchronizer. All logic below uses the synchronized signal rxs.
- Bit FSM, states IDLE, START, DATA, STOP:
  - IDLE: rxs low -> START, clear bit counter.
  - START: after CLKS_PER_BIT/2 clocks, sample rxs. If low -> DATA. If high, treat as a glitch -> IDLE, no byte.
  - DATA: sample every CLKS_PER_BIT clocks. Shift LSB first. After 8 samples -> STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rxs. If high -> raise internal byte_valid for 1 cycle with the byte. If low -> raise internal stop_err for 1 cycle. Either way -> IDLE.
  - A new start bit is accepted in the cycle after leaving STOP. Back-to-back bytes with no idle gap must be received.
- Frame FSM, states WAIT_SYNC, PAYLOAD, DONE:
  - WAIT_SYNC: byte_valid with byte==SYNC_BYTE -> PAYLOAD, cnt=0, gap timer=0. Other bytes and stop_err are ignored silently.
  - PAYLOAD, on byte_valid:
    - next cycle: read_data<=byte, idx<=cnt, update_reg=1 for exactly that cycle.
    - cnt increments; gap timer clears.
    - SYNC_BYTE values here are ordinary data.
    - if cnt==NUM_BYTES-1 -> DONE.
  - DONE: pc_ready=1 for exactly one cycle, the cycle immediately after the update_reg pulse for idx 60, so the register write lands before pc_ready. Then -> WAIT_SYNC.
  - PAYLOAD, stop_err: frame_err=1 for one cycle -> WAIT_SYNC. No update_reg for that byte, no pc_ready.
  - PAYLOAD, gap timer reaches TIMEOUT_CLKS with no byte_valid: frame_err=1 for one cycle -> WAIT_SYNC. The timer runs only in PAYLOAD.
- Timing and exclusivity:
  - Latency: update_reg rises 2 clocks after the stop-bit mid-sample edge.
  - update_reg, pc_ready and frame_err are never high in the same cycle.
  - Registers already written by a partial packet are not rolled back.
- Widths: cnt is 6 bits and never exceeds NUM_BYTES-1. The gap timer is 16 bits and saturates. The bit-period counter is wide enough for CLKS_PER_BIT.

Test Plan:
(All use CLKS_PER_BIT=8, TIMEOUT_CLKS=200.)
1. Send A5 then 61 bytes with value = i XOR 8'h5A, i=0..60 -> 61 update_reg pulses, each carrying idx=i and read_data=i^5A. pc_ready is high exactly one cycle, the cycle after the idx=60 strobe. frame_err stays 0.
2. Send 00, 12, 3C before A5, then a full packet -> no update_reg until after A5. Then 61 strobes starting at idx 0 with correct data.
3. Drive rx low for 2 clocks then high, with no further activity -> no byte and no strobes. Bit FSM returns to IDLE; the following A5 plus packet completes normally.
4. A5, then 10 good bytes, then a byte with stop bit 0 -> 10 update_reg pulses (idx 0..9), one frame_err pulse, no pc_ready. A subsequent full packet completes with idx restarting at 0.
5. A5, 20 bytes, then rx idle for 250 clocks -> frame_err pulses once at gap 200. The next A5 packet completes with pc_ready.
6. Assert reset for one cycle mid-data-bit of payload byte 30 -> next cycle idx=3F, all strobes 0. A new A5 packet yields 61 strobes and pc_ready; a payload byte equal to A5 at idx 5 is written as data.

Source files
------------

// File: rtl/ia_uart_frame_loader.sv
// ia_uart_frame_loader
// Input-assembly front end: receives 8N1 UART bytes on a single pin, waits for
// the sync header, then frames a fixed-length scene packet and presents every
// payload byte as a byte/index/strobe triple for the top-level register file.
// A single pc_ready pulse follows the write of the last payload byte; a
// frame_err pulse reports a packet aborted by a bad stop bit or a gap timeout.
module ia_uart_frame_loader #(
    parameter int          CLKS_PER_BIT = 217,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          NUM_BYTES    = 61,
    parameter int          TIMEOUT_CLKS = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] read_data,
    output logic [5:0] idx,
    output logic       update_reg,
    output logic       pc_ready,
    output logic       frame_err
);

    // Bit-period counter width: must hold CLKS_PER_BIT-1.
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [5:0]    LAST_IDX = 6'(NUM_BYTES - 1);
    localparam logic [15:0]   GAP_MAX  = 16'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        BIT_IDLE  = 2'd0,
        BIT_START = 2'd1,
        BIT_DATA  = 2'd2,
        BIT_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [1:0] {
        FR_WAIT_SYNC = 2'd0,
        FR_PAYLOAD   = 2'd1,
        FR_DONE      = 2'd2
    } frame_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (line idles high, so the flops reset high too)
    // ------------------------------------------------------------------
    logic rx_meta_r;
    logic rxs_r;

    // Two-flop synchronizer bringing the asynchronous rx pin into clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // ------------------------------------------------------------------
    // Bit FSM: start detection, mid-bit sampling, stop-bit check
    // ------------------------------------------------------------------
    bit_state_t     bit_state_r, bit_state_s;
    logic [CW-1:0]  clk_cnt_r,   clk_cnt_s;
    logic [2:0]     bit_cnt_r,   bit_cnt_s;
    logic [7:0]     shift_r,     shift_s;
    logic           byte_valid_r, byte_valid_s;
    logic           stop_err_r,   stop_err_s;

    // Bit FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_state_r  <= BIT_IDLE;
            clk_cnt_r    <= '0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            stop_err_r   <= 1'b0;
        end else begin
            bit_state_r  <= bit_state_s;
            clk_cnt_r    <= clk_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            byte_valid_r <= byte_valid_s;
            stop_err_r   <= stop_err_s;
        end
    end

    // Bit FSM next-state: half-bit qualify the start, then sample each bit centre.
    always_comb begin
        bit_state_s  = bit_state_r;
        clk_cnt_s    = clk_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        byte_valid_s = 1'b0;
        stop_err_s   = 1'b0;
        case (bit_state_r)
            BIT_IDLE: begin
                clk_cnt_s = '0;
                bit_cnt_s = 3'd0;
                if (!rxs_r) begin
                    bit_state_s = BIT_START;
                end else begin
                    bit_state_s = BIT_IDLE;
                end
            end
            BIT_START: begin
                if (clk_cnt_r == HALF_M1) begin
                    clk_cnt_s = '0;
                    // A line that is high again at mid-start was only a glitch.
                    if (!rxs_r) begin
                        bit_state_s = BIT_DATA;
                    end else begin
                        bit_state_s = BIT_IDLE;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CW'(1);
                end
            end
            BIT_DATA: begin
                if (clk_cnt_r == FULL_M1) begin
                    clk_cnt_s = '0;
                    shift_s   = {rxs_r, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        bit_state_s = BIT_STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CW'(1);
                end
            end
            BIT_STOP: begin
                if (clk_cnt_r == FULL_M1) begin
                    clk_cnt_s   = '0;
                    bit_state_s = BIT_IDLE;
                    if (rxs_r) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        stop_err_s = 1'b1;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CW'(1);
                end
            end
            default: begin
                bit_state_s = BIT_IDLE;
                clk_cnt_s   = '0;
                bit_cnt_s   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM: sync hunt, payload indexing, completion / abort
    // ------------------------------------------------------------------
    frame_state_t frame_state_r, frame_state_s;
    logic [5:0]   cnt_r,         cnt_s;
    logic [15:0]  gap_r,         gap_s;
    logic [7:0]   read_data_r,   read_data_s;
    logic [5:0]   idx_r,         idx_s;
    logic         update_reg_r,  update_reg_s;
    logic         pc_ready_r,    pc_ready_s;
    logic         frame_err_r,   frame_err_s;

    // Frame FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_state_r <= FR_WAIT_SYNC;
            cnt_r         <= 6'd0;
            gap_r         <= 16'd0;
            read_data_r   <= 8'h00;
            idx_r         <= 6'h3F;
            update_reg_r  <= 1'b0;
            pc_ready_r    <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            frame_state_r <= frame_state_s;
            cnt_r         <= cnt_s;
            gap_r         <= gap_s;
            read_data_r   <= read_data_s;
            idx_r         <= idx_s;
            update_reg_r  <= update_reg_s;
            pc_ready_r    <= pc_ready_s;
            frame_err_r   <= frame_err_s;
        end
    end

    // Frame FSM next-state; strobes default low so each lasts one cycle.
    always_comb begin
        frame_state_s = frame_state_r;
        cnt_s         = cnt_r;
        gap_s         = gap_r;
        read_data_s   = read_data_r;
        idx_s         = idx_r;
        update_reg_s  = 1'b0;
        pc_ready_s    = 1'b0;
        frame_err_s   = 1'b0;
        case (frame_state_r)
            FR_WAIT_SYNC: begin
                // Gap timer is idle outside a packet; stray bytes and
                // framing errors are dropped silently here.
                gap_s = 16'd0;
                if (byte_valid_r && (shift_r == SYNC_BYTE)) begin
                    frame_state_s = FR_PAYLOAD;
                    cnt_s         = 6'd0;
                end else begin
                    frame_state_s = FR_WAIT_SYNC;
                end
            end
            FR_PAYLOAD: begin
                if (byte_valid_r) begin
                    // Sync byte values are plain data inside a packet.
                    read_data_s  = shift_r;
                    idx_s        = cnt_r;
                    update_reg_s = 1'b1;
                    gap_s        = 16'd0;
                    if (cnt_r == LAST_IDX) begin
                        frame_state_s = FR_DONE;
                    end else begin
                        cnt_s = cnt_r + 6'd1;
                    end
                end else if (stop_err_r) begin
                    frame_err_s   = 1'b1;
                    frame_state_s = FR_WAIT_SYNC;
                end else if (gap_r >= GAP_MAX) begin
                    frame_err_s   = 1'b1;
                    frame_state_s = FR_WAIT_SYNC;
                end else begin
                    if (gap_r != 16'hFFFF) begin
                        gap_s = gap_r + 16'd1;
                    end else begin
                        gap_s = gap_r;
                    end
                end
            end
            FR_DONE: begin
                // DONE coincides with the final update_reg cycle, so the
                // registered pc_ready lands exactly one cycle after it.
                pc_ready_s    = 1'b1;
                frame_state_s = FR_WAIT_SYNC;
            end
            default: begin
                frame_state_s = FR_WAIT_SYNC;
                cnt_s         = 6'd0;
                gap_s         = 16'd0;
            end
        endcase
    end

    assign read_data  = read_data_r;
    assign idx        = idx_r;
    assign update_reg = update_reg_r;
    assign pc_ready   = pc_ready_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_ia_uart_frame_loader.sv
// Testbench for ia_uart_frame_loader: serialises 8N1 bytes onto rx, keeps a
// scoreboard of expected (idx, data) writes and checks strobes every cycle.
module tb_ia_uart_frame_loader;

    localparam int CPB = 8;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] read_data;
    logic [5:0] idx;
    logic       update_reg;
    logic       pc_ready;
    logic       frame_err;

    ia_uart_frame_loader #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5),
        .NUM_BYTES    (61),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .read_data  (read_data),
        .idx        (idx),
        .update_reg (update_reg),
        .pc_ready   (pc_ready),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] idx;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        bit pre;        // send 00,12,3C before the sync byte
        int n_good;     // good payload bytes
        bit bad_stop;   // follow with a byte whose stop bit is 0
        bit long_idle;  // idle 250 clocks after the payload
        bit a5_at5;     // payload byte 5 equals the sync value
        int exp_upd;
        int exp_pc;
        int exp_err;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   upd_cnt, pc_cnt, err_cnt;
    bit   prev60;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One clock; outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (update_reg) begin
            if (exp_q.size() == 0) begin
                check("upd_unexpected", int'(idx), -1);
            end else begin
                e = exp_q.pop_front();
                check("upd_idx", int'(idx), int'(e.idx));
                check("upd_data", int'(read_data), int'(e.data));
            end
            upd_cnt++;
        end
        if (pc_ready) begin
            check("pc_after_idx60", int'(prev60), 1);
            pc_cnt++;
        end
        if (frame_err) err_cnt++;
        if (update_reg || pc_ready || frame_err)
            check("strobe_exclusive", int'(update_reg) + int'(pc_ready) + int'(frame_err), 1);
        prev60 = update_reg && (idx == 6'd60);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        ticks(CPB);
        for (int j = 0; j < 8; j++) begin
            rx = b[j];
            ticks(CPB);
        end
        rx = stop;
        ticks(CPB);
        rx = 1'b1;
    endtask

    task automatic send_payload(input int i, input logic [7:0] b);
        exp_t e;
        e.idx  = 6'(i);
        e.data = b;
        exp_q.push_back(e);
        send_byte(b, 1'b1);
    endtask

    task automatic clear_counts();
        upd_cnt = 0;
        pc_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        logic [7:0] b;
        clear_counts();
        if (v.pre) begin
            send_byte(8'h00, 1'b1);
            send_byte(8'h12, 1'b1);
            send_byte(8'h3C, 1'b1);
        end
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < v.n_good; i++) begin
            b = 8'(i) ^ 8'h5A;
            if (v.a5_at5 && i == 5) b = 8'hA5;
            send_payload(i, b);
        end
        if (v.bad_stop) begin
            b = 8'(v.n_good) ^ 8'h5A;
            send_byte(b, 1'b0);
            rx = 1'b1;
            ticks(20 * CPB);
        end
        if (v.long_idle) ticks(250);
        ticks(40);
        $display("vector %0d: upd=%0d pc=%0d err=%0d", n, upd_cnt, pc_cnt, err_cnt);
        check("vec_upd_count", upd_cnt, v.exp_upd);
        check("vec_pc_count", pc_cnt, v.exp_pc);
        check("vec_err_count", err_cnt, v.exp_err);
        check("vec_queue_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    vec_t vecs[6];
    vec_t full;
    logic [7:0] b30;

    initial begin
        vecs[0] = '{pre:1'b0, n_good:61, bad_stop:1'b0, long_idle:1'b0, a5_at5:1'b0, exp_upd:61, exp_pc:1, exp_err:0};
        vecs[1] = '{pre:1'b1, n_good:61, bad_stop:1'b0, long_idle:1'b0, a5_at5:1'b0, exp_upd:61, exp_pc:1, exp_err:0};
        vecs[2] = '{pre:1'b0, n_good:10, bad_stop:1'b1, long_idle:1'b0, a5_at5:1'b0, exp_upd:10, exp_pc:0, exp_err:1};
        vecs[3] = '{pre:1'b0, n_good:61, bad_stop:1'b0, long_idle:1'b0, a5_at5:1'b0, exp_upd:61, exp_pc:1, exp_err:0};
        vecs[4] = '{pre:1'b0, n_good:20, bad_stop:1'b0, long_idle:1'b1, a5_at5:1'b0, exp_upd:20, exp_pc:0, exp_err:1};
        vecs[5] = '{pre:1'b0, n_good:61, bad_stop:1'b0, long_idle:1'b0, a5_at5:1'b0, exp_upd:61, exp_pc:1, exp_err:0};
        full    = vecs[0];
        prev60  = 1'b0;
        clear_counts();

        // Reset state
        reset = 1'b1;
        rx    = 1'b1;
        ticks(3);
        check("rst_idx", int'(idx), 63);
        check("rst_read_data", int'(read_data), 0);
        check("rst_strobes", int'(update_reg) + int'(pc_ready) + int'(frame_err), 0);
        reset = 1'b0;
        ticks(10);

        // Packets, prefix garbage, bad stop bit, gap timeout
        for (int n = 0; n < 6; n++) run_vec(vecs[n], n);

        // Start-bit glitch: no byte, then a normal packet
        clear_counts();
        rx = 1'b0;
        ticks(2);
        rx = 1'b1;
        ticks(40);
        check("glitch_no_upd", upd_cnt, 0);
        check("glitch_no_err", err_cnt, 0);
        run_vec(full, 6);

        // Reset in the middle of payload byte 30
        clear_counts();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 30; i++) send_payload(i, 8'(i) ^ 8'h5A);
        b30 = 8'd30 ^ 8'h5A;
        rx = 1'b0;
        ticks(CPB);
        rx = b30[0];
        ticks(CPB);
        rx = b30[1];
        ticks(3);
        reset = 1'b1;
        tick();
        check("midrst_idx", int'(idx), 63);
        check("midrst_strobes", int'(update_reg) + int'(pc_ready) + int'(frame_err), 0);
        reset = 1'b0;
        rx    = 1'b1;
        check("midrst_upd_before", upd_cnt, 30);
        check("midrst_queue", exp_q.size(), 0);
        exp_q.delete();
        ticks(100);
        check("midrst_no_strobe_after", upd_cnt + pc_cnt + err_cnt, 30);
        full.a5_at5 = 1'b1;
        run_vec(full, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
